// File: rtl/clkdiv_sequencer.sv
// Programmable clock divider with glitch-free divisor hand-over and a drain-to-stop
// sequence: divisor changes and stop requests only take effect on a period boundary.
module clkdiv_sequencer #(
    parameter int WIDTH       = 28,
    parameter int DEFAULT_DIV = 10
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clock_out,
    output logic             tick,
    output logic             busy
);

    typedef enum logic [1:0] {STOP, RUN, PEND, DRAIN} state_t;

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

    state_t           state, state_next;
    logic [WIDTH-1:0] cur_div, cur_div_next;
    logic [WIDTH-1:0] nxt_div, nxt_div_next;
    logic [WIDTH-1:0] count, count_next;
    logic             drain;
    logic             active, wrap, xfer, legal;
    logic             clock_out_next, tick_next, cfg_err_next;

    assign active    = (state != STOP);
    assign cfg_ready = (state == STOP) || (state == RUN);
    assign busy      = active;
    assign xfer      = cfg_valid && cfg_ready;
    assign legal     = (cfg_div > WIDTH'(1));
    // cur_div >= 2 always, so cur_div-1 cannot underflow and count+1 cannot overflow
    assign wrap      = active && (count == cur_div - WIDTH'(1));

    // Outputs are registered from the pre-edge state, hence the two-edge start latency
    assign clock_out_next = active && (count < (cur_div >> 1));
    assign tick_next      = active && (count == '0);
    assign cfg_err_next   = xfer && !legal;

    always_comb begin
        state_next   = state;
        cur_div_next = cur_div;
        nxt_div_next = nxt_div;
        count_next   = '0;
        if (active) begin
            count_next = wrap ? '0 : count + WIDTH'(1);
        end
        case (state)
            STOP: begin
                if (xfer && legal) begin
                    cur_div_next = cfg_div;
                end
                if (enable) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (xfer && legal) begin
                    nxt_div_next = cfg_div;
                    state_next   = PEND;
                end else if (!enable) begin
                    state_next = DRAIN;
                end
            end
            PEND: begin
                if (wrap) begin
                    cur_div_next = nxt_div;
                    state_next   = enable ? RUN : STOP;
                end
            end
            DRAIN: begin
                // re-enable resumes without disturbing the counter
                if (enable) begin
                    state_next = RUN;
                end else if (wrap && drain) begin
                    state_next = STOP;
                end
            end
            default: state_next = STOP;
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state     <= STOP;
            cur_div   <= DIV_RST;
            nxt_div   <= DIV_RST;
            count     <= '0;
            drain     <= 1'b0;
            clock_out <= 1'b0;
            tick      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state     <= state_next;
            cur_div   <= cur_div_next;
            nxt_div   <= nxt_div_next;
            count     <= count_next;
            drain     <= (state_next == DRAIN);
            clock_out <= clock_out_next;
            tick      <= tick_next;
            cfg_err   <= cfg_err_next;
        end
    end

endmodule
